fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_pkg.sv | 10 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the frame-level FIFO write-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker (rr_pick): first requester
// found searching upward from last_grant+1, wrapping at NUM_REQ.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       found
);

  localparam int IW = $clog2(NUM_REQ);

  int          j;
  logic [IW-1:0] jj;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j  = (int'(last_grant) + i) % NUM_REQ;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found  = 1'b1;
        winner = jj;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-level round-robin arbiter for a shared FIFO write port.
// A frame starts only with FRAME_MAX beats of free space.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int PTR_WIDTH  = 4,
  parameter int FRAME_MAX  = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic                          FIFO_WR_EN,
  output logic [DATA_WIDTH-1:0]         FIFO_WR_DATA,
  input  logic                          FIFO_WR_FULL,
  input  logic [PTR_WIDTH:0]            FIFO_WR_CNT,
  output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID,
  output logic                          BUSY,
  output logic                          OVERSIZE
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_MAX + 1);
  localparam logic [PTR_WIDTH:0] CAP =
    {1'b1, {PTR_WIDTH{1'b0}}};
  localparam logic [PTR_WIDTH:0] FM_SPACE =
    FRAME_MAX[PTR_WIDTH:0];
  localparam logic [CW-1:0] CNT_MAX = FRAME_MAX[CW-1:0];

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] pick_id;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick_found;
  logic          space_ok;
  logic          beat_last;
  logic [PTR_WIDTH:0] free;

  // Count is pessimistic (read-side sync lag); used as-is.
  assign free     = CAP - FIFO_WR_CNT;
  assign space_ok = free >= FM_SPACE;

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req       (REQ_VALID),
    .last_grant(last_q),
    .winner    (pick_id),
    .found     (pick_found)
  );

  assign beat_last    = REQ_LAST[grant_q];
  assign FIFO_WR_DATA =
    REQ_DATA[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign GRANT_ID     = grant_q;
  assign BUSY         = (state_q == XFER);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    REQ_READY  = '0;
    FIFO_WR_EN = 1'b0;
    OVERSIZE   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found && space_ok) begin
          grant_d = pick_id;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        REQ_READY[grant_q] = ~FIFO_WR_FULL;
        FIFO_WR_EN = REQ_VALID[grant_q] & ~FIFO_WR_FULL;
        if (FIFO_WR_EN) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          OVERSIZE = (cnt_q == CNT_MAX - 1'b1) && !beat_last;
          if (beat_last) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant starts at the top index so requester 0 wins first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized self-checking bench for fifo_wr_arbiter against a
// frame-level reference model and per-requester data scoreboard.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int PW = 4;
  localparam int FM = 8;
  localparam int GW = 2;
  localparam int CAPACITY = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [NR-1:0]    REQ_VALID = '0;
  logic [NR*DW-1:0] REQ_DATA = '0;
  logic [NR-1:0]    REQ_LAST = '0;
  logic [NR-1:0]    REQ_READY;
  logic             FIFO_WR_EN;
  logic [DW-1:0]    FIFO_WR_DATA;
  logic             FIFO_WR_FULL = 1'b0;
  logic [PW:0]      FIFO_WR_CNT = '0;
  logic [GW-1:0]    GRANT_ID;
  logic             BUSY;
  logic             OVERSIZE;

  always #5 CLK = ~CLK;

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW),
    .PTR_WIDTH(PW), .FRAME_MAX(FM)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY),
    .FIFO_WR_EN(FIFO_WR_EN), .FIFO_WR_DATA(FIFO_WR_DATA),
    .FIFO_WR_FULL(FIFO_WR_FULL), .FIFO_WR_CNT(FIFO_WR_CNT),
    .GRANT_ID(GRANT_ID), .BUSY(BUSY), .OVERSIZE(OVERSIZE)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  beat_t         drv_q[NR][$];
  logic [DW-1:0] sb_q[NR][$];

  int n_cmp = 0;
  int n_bad = 0;

  bit          full;
  int          cnt;
  bit [NR-1:0] gap;

  // Frame-level reference: who owns the port, beats taken so far.
  bit m_busy;
  int m_owner, m_last, m_beats;

  int wr_count, ovs_count, ovs_at;
  int grant_log[$];
  bit prev_busy, obs_busy, obs_stall;
  int obs_gid;

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_last = NR - 1; m_beats = 0;
    prev_busy = 0;
    for (int i = 0; i < NR; i++) begin
      drv_q[i].delete();
      sb_q[i].delete();
    end
  endfunction

  function automatic void push_frame(int r, int len);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.d = {$urandom, $urandom};
      b.last = (k == len - 1);
      drv_q[r].push_back(b);
      sb_q[r].push_back(b.d);
    end
  endfunction

  function automatic int rr_ref(bit [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(m_last + k) % NR]) return (m_last + k) % NR;
    return -1;
  endfunction

  task automatic tick();
    logic [NR-1:0] v, l, e_rdy, rdy_s;
    logic e_wr, e_ovs;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < NR; i++) begin
      v[i] = (drv_q[i].size() > 0) && !gap[i];
      if (drv_q[i].size() > 0) begin
        REQ_DATA[i*DW +: DW] = drv_q[i][0].d;
        l[i] = drv_q[i][0].last;
      end else begin
        REQ_DATA[i*DW +: DW] = {$urandom, $urandom};
        l[i] = 1'($urandom);
      end
    end
    REQ_VALID = v;
    REQ_LAST = l;
    FIFO_WR_FULL = full;
    FIFO_WR_CNT = cnt[PW:0];
    @(negedge CLK);
    e_rdy = '0;
    if (m_busy && !full) e_rdy[m_owner] = 1'b1;
    e_wr = m_busy && v[m_owner] && !full;
    e_ovs = e_wr && (m_beats + 1 == FM) && !l[m_owner];
    n_cmp += 5;
    if (BUSY !== m_busy) begin
      n_bad++;
      $display("FAIL busy: got %b want %b t=%0t", BUSY, m_busy, $time);
    end
    if (GRANT_ID !== GW'(m_owner)) begin
      n_bad++;
      $display("FAIL grant_id: got %0d want %0d t=%0t",
               GRANT_ID, m_owner, $time);
    end
    if (REQ_READY !== e_rdy) begin
      n_bad++;
      $display("FAIL ready: got %b want %b t=%0t",
               REQ_READY, e_rdy, $time);
    end
    if (FIFO_WR_EN !== e_wr) begin
      n_bad++;
      $display("FAIL wr_en: got %b want %b t=%0t",
               FIFO_WR_EN, e_wr, $time);
    end
    if (OVERSIZE !== e_ovs) begin
      n_bad++;
      $display("FAIL oversize: got %b want %b t=%0t",
               OVERSIZE, e_ovs, $time);
    end
    if (e_wr) begin
      n_cmp++;
      if (sb_q[m_owner].size() == 0) begin
        n_bad++;
        $display("FAIL wr_data: scoreboard empty for req %0d",
                 m_owner);
      end else begin
        exp_d = sb_q[m_owner].pop_front();
        if (FIFO_WR_DATA !== exp_d) begin
          n_bad++;
          $display("FAIL wr_data: got %h want %h t=%0t",
                   FIFO_WR_DATA, exp_d, $time);
        end
      end
    end
    if (FIFO_WR_EN) wr_count++;
    if (OVERSIZE) begin
      ovs_count++;
      ovs_at = wr_count;
    end
    if (BUSY && !prev_busy) grant_log.push_back(int'(GRANT_ID));
    prev_busy = BUSY;
    obs_busy = BUSY;
    obs_gid = int'(GRANT_ID);
    obs_stall = BUSY && (REQ_READY == '0) && !FIFO_WR_EN;
    rdy_s = REQ_READY;
    @(posedge CLK);
    for (int i = 0; i < NR; i++)
      if (rdy_s[i] && v[i]) void'(drv_q[i].pop_front());
    if (m_busy) begin
      if (e_wr) begin
        if (m_beats < FM) m_beats++;
        if (l[m_owner]) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end
    end else if (v != '0 && CAPACITY - cnt >= FM) begin
      m_owner = rr_ref(v);
      m_busy = 1;
      m_beats = 0;
    end
    #1;
  endtask

  task automatic drain(int lim);
    int n;
    bit pend;
    full = 0; cnt = 0; gap = '0; n = 0;
    do begin
      pend = m_busy;
      for (int i = 0; i < NR; i++)
        if (drv_q[i].size() > 0) pend = 1;
      if (pend) begin
        tick();
        n++;
      end
    end while (pend && n < lim);
    n_cmp++;
    if (pend) begin
      n_bad++;
      $display("FAIL drain: still pending after %0d cycles", n);
    end
  endtask

  task automatic check_zero_outputs(string tag);
    n_cmp++;
    if (REQ_READY !== '0 || FIFO_WR_EN !== 1'b0 ||
        BUSY !== 1'b0 || OVERSIZE !== 1'b0 ||
        GRANT_ID !== '0) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b we=%b busy=%b ovs=%b gid=%0d want all 0",
               tag, REQ_READY, FIFO_WR_EN, BUSY, OVERSIZE, GRANT_ID);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    REQ_VALID = '1;
    REQ_LAST = '1;
    #2;
    check_zero_outputs("reset_state");
    @(posedge CLK);
    #1;
    check_zero_outputs("reset_state_hold");
    RST = 1'b0;
    model_reset();
    full = 0; cnt = 0; gap = '0;
    tick();
  endtask

  task automatic test_single_frame();
    int w0;
    w0 = wr_count;
    grant_log.delete();
    push_frame(1, 3);
    drain(50);
    tick();
    n_cmp += 3;
    if (grant_log.size() < 1 || grant_log[0] != 1) begin
      n_bad++;
      $display("FAIL single_grant: got %p want 1", grant_log);
    end
    if (wr_count - w0 != 3) begin
      n_bad++;
      $display("FAIL single_writes: got %0d want 3", wr_count - w0);
    end
    if (obs_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: busy got %b want 0", obs_busy);
    end
  endtask

  task automatic test_fairness();
    int want[5] = '{0, 1, 2, 3, 0};
    RST = 1'b1;
    #1;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int r = 0; r < NR; r++) begin
      push_frame(r, 2);
      push_frame(r, 2);
    end
    grant_log.delete();
    repeat (20) tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (grant_log.size() <= k || grant_log[k] != want[k]) begin
        n_bad++;
        $display("FAIL fair_order[%0d]: got %p want %0d",
                 k, grant_log, want[k]);
      end
    end
    drain(100);
  endtask

  task automatic test_space_gate();
    cnt = 9;
    push_frame(0, 2);
    repeat (6) begin
      tick();
      n_cmp++;
      if (obs_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL space_gate_hold: busy got %b want 0", obs_busy);
      end
    end
    cnt = 8;
    tick();
    tick();
    n_cmp++;
    if (obs_busy !== 1'b1 || obs_gid != 0) begin
      n_bad++;
      $display("FAIL space_gate_open: busy=%b gid=%0d want 1/0",
               obs_busy, obs_gid);
    end
    drain(50);
  endtask

  task automatic test_full_stall();
    int w0, stall, n;
    w0 = wr_count;
    push_frame(3, 6);
    n = 0;
    while (wr_count - w0 < 2 && n < 30) begin
      tick();
      n++;
    end
    full = 1;
    stall = 0;
    repeat (5) begin
      tick();
      if (obs_stall && obs_gid == 3) stall++;
    end
    full = 0;
    drain(50);
    n_cmp += 2;
    if (stall != 5) begin
      n_bad++;
      $display("FAIL full_stall: stalled %0d cycles want 5", stall);
    end
    if (wr_count - w0 != 6) begin
      n_bad++;
      $display("FAIL full_writes: got %0d want 6", wr_count - w0);
    end
  endtask

  task automatic test_oversize();
    int w0;
    w0 = wr_count;
    ovs_count = 0;
    ovs_at = 0;
    push_frame(2, 10);
    drain(60);
    n_cmp += 3;
    if (ovs_count != 1) begin
      n_bad++;
      $display("FAIL ovs_count: got %0d want 1", ovs_count);
    end
    if (ovs_at - w0 != 8) begin
      n_bad++;
      $display("FAIL ovs_beat: got %0d want 8", ovs_at - w0);
    end
    if (wr_count - w0 != 10) begin
      n_bad++;
      $display("FAIL ovs_writes: got %0d want 10", wr_count - w0);
    end
    ovs_count = 0;
    push_frame(1, FM);
    drain(60);
    n_cmp++;
    if (ovs_count != 0) begin
      n_bad++;
      $display("FAIL ovs_exact: got %0d pulses want 0", ovs_count);
    end
  endtask

  task automatic test_reset_mid();
    int w0, n;
    w0 = wr_count;
    push_frame(2, 4);
    n = 0;
    while (wr_count - w0 < 2 && n < 30) begin
      tick();
      n++;
    end
    RST = 1'b1;
    #1;
    check_zero_outputs("reset_async");
    repeat (2) begin
      @(negedge CLK);
      n_cmp++;
      if (FIFO_WR_EN !== 1'b0 || REQ_READY !== '0) begin
        n_bad++;
        $display("FAIL reset_no_write: we=%b rdy=%b want 0",
                 FIFO_WR_EN, REQ_READY);
      end
    end
    @(posedge CLK);
    #1;
    model_reset();
    RST = 1'b0;
    push_frame(1, 3);
    push_frame(0, 2);
    grant_log.delete();
    drain(50);
    n_cmp++;
    if (grant_log.size() < 2 ||
        grant_log[0] != 0 || grant_log[1] != 1) begin
      n_bad++;
      $display("FAIL reset_first_grant: got %p want 0,1", grant_log);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 600; it++) begin
      for (int r = 0; r < NR; r++)
        if (drv_q[r].size() < 4 && $urandom_range(0, 3) == 0)
          push_frame(r, int'($urandom_range(1, 12)));
      full = ($urandom_range(0, 4) == 0);
      cnt = ($urandom_range(0, 3) == 0) ?
            int'($urandom_range(9, 16)) :
            int'($urandom_range(0, 8));
      gap = NR'($urandom & $urandom);
      tick();
    end
    drain(2000);
  endtask

  initial begin
    model_reset();
    wr_count = 0;
    ovs_count = 0;
    ovs_at = 0;
    @(posedge CLK);
    #1;
    test_reset();
    test_single_frame();
    test_fairness();
    test_space_gate();
    test_full_stall();
    test_oversize();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
